// File: rtl/piradip_axis_sample_player.sv
// Plays a span of a sample memory out of an AXI4-Stream manager port.
// The span can loop or play once. Two samples are prefetched through a one-cycle-latency
// read port, so the output can move one sample per cycle.
module piradip_axis_sample_player #(
    parameter int unsigned STREAM_OFFSET_WIDTH = 5,
    parameter int unsigned DATA_WIDTH          = 32
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           stream_update,
    input  logic                           stream_active,
    input  logic                           stream_one_shot,
    input  logic [STREAM_OFFSET_WIDTH-1:0] stream_start_offset,
    input  logic [STREAM_OFFSET_WIDTH-1:0] stream_end_offset,
    output logic                           stream_stopped,
    output logic                           mem_en,
    output logic [STREAM_OFFSET_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [STREAM_OFFSET_WIDTH-1:0] PTR_ONE = STREAM_OFFSET_WIDTH'(1);

    logic [1:0]                     r_state;
    logic [1:0]                     w_state_next;
    logic [STREAM_OFFSET_WIDTH-1:0] r_ptr;
    logic [STREAM_OFFSET_WIDTH-1:0] r_end;
    logic                           r_one_shot;
    logic                           r_stopped;
    logic                           r_inflight;
    logic                           r_inflight_last;
    logic [DATA_WIDTH-1:0]          r_fifo_data [2];
    logic [1:0]                     r_fifo_last;
    logic                           r_head;
    logic                           r_tail;
    logic [1:0]                     r_count;

    logic       w_valid;
    logic       w_pop;
    logic       w_push;
    logic       w_start;
    logic       w_stop;
    logic       w_issue;
    logic       w_at_end;
    logic [2:0] w_occupancy;

    assign w_valid  = (r_count != 2'd0);
    assign w_pop    = w_valid & m_axis_tready;
    assign w_push   = r_inflight;
    assign w_start  = (r_state == IDLE) & stream_update & stream_active;
    assign w_stop   = (r_state == RUN) & stream_update & ~stream_active;
    assign w_at_end = (r_ptr == r_end);

    // A sample leaving this cycle frees its slot, which keeps the stream gap-free at tready=1
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == RUN) & ~w_stop & (w_occupancy < 3'd2);

    assign mem_en         = w_issue;
    assign mem_addr       = r_ptr;
    assign stream_stopped = r_stopped;
    assign m_axis_tvalid  = w_valid;
    assign m_axis_tdata   = r_fifo_data[r_head];
    assign m_axis_tlast   = w_valid & r_fifo_last[r_head];

    // Next-state decode for the run/drain sequencing
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_next = RUN;
            end
            RUN: begin
                if (w_stop) begin
                    w_state_next = DRAIN;
                end else if (w_issue && w_at_end && r_one_shot) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_valid && !r_inflight) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State and the registered idle flag
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_stopped <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_stopped <= (w_state_next == IDLE);
        end
    end

    // Read pointer: latched on start, then stepped or reloaded from the live offsets per read
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr      <= '0;
            r_end      <= '0;
            r_one_shot <= 1'b0;
        end else if (w_start) begin
            r_ptr      <= stream_start_offset;
            r_end      <= stream_end_offset;
            r_one_shot <= stream_one_shot;
        end else if (w_issue) begin
            if (w_at_end && !r_one_shot) begin
                r_ptr <= stream_start_offset;
                r_end <= stream_end_offset;
            end else begin
                r_ptr <= r_ptr + PTR_ONE;
            end
        end
    end

    // Track the single outstanding read and whether it is the period end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & w_at_end;
        end
    end

    // Two-entry output FIFO fed by the read data one cycle after each read
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
            r_fifo_last <= 2'b00;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_tail] <= mem_rdata;
                r_fifo_last[r_tail] <= r_inflight_last;
                r_tail              <= ~r_tail;
            end
            if (w_pop) r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: doc/piradip_axis_sample_player.md
PIRADIP_AXIS_SAMPLE_PLAYER -- requirements
Module: piradip_axis_sample_player

Interface
REQ-001 SHALL have parameter STREAM_OFFSET_WIDTH, default 5, sample-memory address width in samples.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, sample width in bits.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port stream_update, input, 1, one-cycle pulse: a new active/one_shot pair is valid.
REQ-006 SHALL have port stream_active, input, 1, requested run state, sampled only when stream_update=1.
REQ-007 SHALL have port stream_one_shot, input, 1, 1 = play once, 0 = loop; sampled with stream_update.
REQ-008 SHALL have ports stream_start_offset and stream_end_offset, input, STREAM_OFFSET_WIDTH each, first and last sample address (inclusive).
REQ-009 SHALL have port stream_stopped, output, 1, high while the block is idle.
REQ-010 SHALL have ports mem_en (output, 1), mem_addr (output, STREAM_OFFSET_WIDTH), mem_rdata (input, DATA_WIDTH), a read port with exactly one cycle of read latency.
REQ-011 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1), an AXI4-Stream manager.

Function
REQ-012 SHALL implement states IDLE, RUN and DRAIN.
REQ-013 SHALL move IDLE->RUN when stream_update=1 and stream_active=1, latching start, end and one_shot, and setting the read pointer to start.
REQ-014 In RUN, SHALL assert mem_en with mem_addr=pointer when (buffered samples + reads in flight) < 2, so the buffer never exceeds 2 entries.
REQ-015 SHALL advance the pointer by 1 modulo 2^STREAM_OFFSET_WIDTH after each read; end < start therefore wraps through the top of memory.
REQ-016 SHALL treat a read at address end as the period end: when looping, it reloads the pointer from the live start offset and latches the live end offset; when one-shot, it goes RUN->DRAIN with no further reads.
REQ-017 SHALL handle start==end as a one-sample period.
REQ-018 SHALL capture mem_rdata one cycle after mem_en into a 2-entry FIFO, tagging the entry as last if its address equalled end.
REQ-019 SHALL drive m_axis_tdata/tvalid/tlast from the FIFO head and pop on tvalid&tready.
REQ-020 SHALL keep tdata and tlast stable while tvalid=1 and tready=0.
REQ-021 SHALL assert tlast on the sample read from end, in every loop iteration.
REQ-022 SHALL give 2-cycle latency from the RUN entry edge to first tvalid (read issue, then capture).
REQ-023 SHALL sustain one sample per cycle while tready=1.
REQ-024 SHALL, on stream_update=1 with stream_active=0 in RUN, stop issuing reads and go to DRAIN; reads in flight complete and are delivered.
REQ-025 SHALL leave DRAIN for IDLE in the cycle after the FIFO is empty and no read is in flight.
REQ-026 SHALL assert stream_stopped only in IDLE, registered.
REQ-027 SHALL ignore stream_update with stream_active=1 in RUN and DRAIN; stream_update with stream_active=0 in IDLE or DRAIN has no effect.
REQ-028 SHALL ignore a change to stream_one_shot in RUN until the next start.

Reset
REQ-029 On aresetn=0, SHALL immediately force IDLE, stream_stopped=1, mem_en=0, m_axis_tvalid=0, m_axis_tlast=0, empty FIFO, pointer=0 and tdata=0.
REQ-030 Reset mid-transfer SHALL discard buffered and in-flight samples; no tvalid follows deassertion without a new start.

Verification
REQ-031 SHALL verify: mem[i]=i, start=2, end=5, one_shot=1, tready=1 -> tdata 2,3,4,5, tlast only on 5, then stream_stopped=1.
REQ-032 SHALL verify: W=5, start=30, end=1, loop -> 30,31,0,1,30,...; tlast on each 1.
REQ-033 SHALL verify: start=end=7, loop -> 7 every cycle with tlast=1.
REQ-034 SHALL verify: random tready, start=0, end=31, one-shot -> all 32 samples in order, none lost or duplicated, tdata stable while stalled.
REQ-035 SHALL verify: stop pulse (active=0) mid-run with tready=0 -> at most 2 more samples after tready returns, then stopped=1.
REQ-036 SHALL verify: aresetn low mid-run -> tvalid=0 and stopped=1 in the same cycle; idle after release.
